seventap_coeff_loader: RTL and testbench

- Upstream coefficient source for the 7-tap systolic preadd filter.
- Accepts a serial stream of seven 18-bit coefficients into a shadow bank and validates the count.
- Atomically swaps the shadow bank into the active bank, which drives the filter's coefficient inputs. The swap is optionally aligned to an external update strobe, so all taps change on the same clock edge and the filter never runs with a mixed coefficient set.

---
 rtl/seventap_coeff_pkg.sv | 19 +
 rtl/seventap_coeff_loader.sv | 116 +++++++++++
 tb/tb_seventap_coeff_loader.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/seventap_coeff_pkg.sv
// Shared types for the 7-tap coefficient loader.
//   NTAPS        number of filter taps fed by the loader
//   COEFF_BITS   width of one coefficient word
//   cl_state_t   loader FSM state
//   coeff_bank_t one full coefficient set, tap k in element [k]
package seventap_coeff_pkg;

  localparam int NTAPS      = 7;
  localparam int COEFF_BITS = 18;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADING = 2'd1,
    ARMED   = 2'd2
  } cl_state_t;

  typedef logic [NTAPS-1:0][COEFF_BITS-1:0] coeff_bank_t;

endpackage

// File: rtl/seventap_coeff_loader.sv
// Coefficient source for the 7-tap systolic preadd filter.
// A serial stream of seven words fills a shadow bank; once complete, the
// shadow bank is copied into the active bank in a single edge so the filter
// never sees a mixed set. With SYNC_UPDATE="TRUE" the copy waits for
// update_en_i; with "FALSE" it happens on the cycle after the bank completes.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   load_start_i           begin / restart a 7-word load
//   dat_i, dat_valid_i     coefficient word stream, tap 0 first
//   update_en_i            swap-permitted strobe (SYNC_UPDATE="TRUE" only)
//   coeff0_o..coeff6_o     active coefficients for taps 0..6
//   update_o               one-cycle pulse with the first new coefficients
//   busy_o                 load open or swap pending
//   armed_o                shadow bank complete, swap pending
//   overrun_o              sticky: a word arrived with no load open
module seventap_coeff_loader
  import seventap_coeff_pkg::*;
#(
  parameter string                         SYNC_UPDATE = "TRUE",
  parameter logic [NTAPS*COEFF_BITS-1:0]   INIT_COEFF  = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_start_i,
  input  logic [COEFF_BITS-1:0] dat_i,
  input  logic                  dat_valid_i,
  input  logic                  update_en_i,
  output logic [COEFF_BITS-1:0] coeff0_o,
  output logic [COEFF_BITS-1:0] coeff1_o,
  output logic [COEFF_BITS-1:0] coeff2_o,
  output logic [COEFF_BITS-1:0] coeff3_o,
  output logic [COEFF_BITS-1:0] coeff4_o,
  output logic [COEFF_BITS-1:0] coeff5_o,
  output logic [COEFF_BITS-1:0] coeff6_o,
  output logic                  update_o,
  output logic                  busy_o,
  output logic                  armed_o,
  output logic                  overrun_o
);

  localparam bit         SYNC     = (SYNC_UPDATE == "TRUE");
  localparam logic [2:0] LAST_PTR = 3'(NTAPS - 1);

  cl_state_t   state;
  logic [2:0]  ptr;
  coeff_bank_t shadow;
  coeff_bank_t active;

  logic swap_ok;
  assign swap_ok = SYNC ? update_en_i : 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      ptr       <= '0;
      shadow    <= '0;
      active    <= coeff_bank_t'(INIT_COEFF);
      update_o  <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      update_o <= 1'b0;
      if (load_start_i) begin
        // Start wins in every state: it opens a fresh load, cancels any
        // pending swap and clears overrun. A same-cycle word is tap 0.
        state     <= LOADING;
        overrun_o <= 1'b0;
        if (dat_valid_i) begin
          shadow[0] <= dat_i;
          ptr       <= 3'd1;
        end else begin
          ptr       <= 3'd0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (dat_valid_i) overrun_o <= 1'b1;
          end
          LOADING: begin
            if (dat_valid_i) begin
              shadow[ptr] <= dat_i;
              if (ptr == LAST_PTR) begin
                ptr   <= '0;
                state <= ARMED;
              end else begin
                ptr   <= ptr + 3'd1;
              end
            end
          end
          ARMED: begin
            // Stray words are dropped; the shadow bank stays intact.
            if (dat_valid_i) overrun_o <= 1'b1;
            if (swap_ok) begin
              active   <= shadow;
              update_o <= 1'b1;
              state    <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy_o   = (state != IDLE);
  assign armed_o  = (state == ARMED);

  assign coeff0_o = active[0];
  assign coeff1_o = active[1];
  assign coeff2_o = active[2];
  assign coeff3_o = active[3];
  assign coeff4_o = active[4];
  assign coeff5_o = active[5];
  assign coeff6_o = active[6];

endmodule

// File: tb/tb_seventap_coeff_loader.sv
// Bench for seventap_coeff_loader: one instance per SYNC_UPDATE setting,
// both fed the same stream. A reference model computes each cycle's
// expected outputs, pushed to a per-instance queue; a monitor pops and
// compares one cycle later.
module tb_seventap_coeff_loader;
  import seventap_coeff_pkg::*;

  localparam logic [125:0] INIT0 = 126'(18'h01000) << 54;
  localparam logic [125:0] INIT1 = {18'h15555, 90'd0, 18'h2AAAA};

  logic        clk = 1'b0;
  logic        rst_i = 1'b1, load_start_i = 1'b0, dat_valid_i = 1'b0, update_en_i = 1'b0;
  logic [17:0] dat_i = '0;

  logic [17:0] c0 [2], c1 [2], c2 [2], c3 [2], c4 [2], c5 [2], c6 [2];
  logic        upd [2], busy [2], armd [2], ovr [2];

  always #5 clk = ~clk;

  seventap_coeff_loader #(.SYNC_UPDATE("FALSE"), .INIT_COEFF(INIT0)) u_async (
    .clk_i(clk), .rst_i(rst_i), .load_start_i(load_start_i), .dat_i(dat_i),
    .dat_valid_i(dat_valid_i), .update_en_i(update_en_i),
    .coeff0_o(c0[0]), .coeff1_o(c1[0]), .coeff2_o(c2[0]), .coeff3_o(c3[0]),
    .coeff4_o(c4[0]), .coeff5_o(c5[0]), .coeff6_o(c6[0]),
    .update_o(upd[0]), .busy_o(busy[0]), .armed_o(armd[0]), .overrun_o(ovr[0]));

  seventap_coeff_loader #(.SYNC_UPDATE("TRUE"), .INIT_COEFF(INIT1)) u_sync (
    .clk_i(clk), .rst_i(rst_i), .load_start_i(load_start_i), .dat_i(dat_i),
    .dat_valid_i(dat_valid_i), .update_en_i(update_en_i),
    .coeff0_o(c0[1]), .coeff1_o(c1[1]), .coeff2_o(c2[1]), .coeff3_o(c3[1]),
    .coeff4_o(c4[1]), .coeff5_o(c5[1]), .coeff6_o(c6[1]),
    .update_o(upd[1]), .busy_o(busy[1]), .armed_o(armd[1]), .overrun_o(ovr[1]));

  // flags = {busy, armed, overrun, update}
  typedef struct packed {
    logic [3:0]   flags;
    logic [125:0] bank;
  } snap_t;

  snap_t q0[$], q1[$];
  int n_cmp = 0, n_bad = 0;

  // Reference model, per instance: is a load open, how many words it holds,
  // is a complete set waiting, the words themselves, the visible set.
  bit           m_open [2], m_pend [2], m_ovr [2], m_upd [2];
  int           m_cnt  [2];
  logic [125:0] m_shad [2], m_act [2];

  function automatic void model_step(input int d);
    bit swap, drop;
    m_upd[d] = 1'b0;
    if (rst_i) begin
      m_open[d] = 0; m_pend[d] = 0; m_ovr[d] = 0; m_cnt[d] = 0;
      m_shad[d] = '0;
      m_act[d]  = (d == 0) ? INIT0 : INIT1;
      return;
    end
    swap = m_pend[d] && !load_start_i && ((d == 1) ? update_en_i : 1'b1);
    drop = dat_valid_i && !load_start_i && !m_open[d];
    if (drop) m_ovr[d] = 1;
    else if (load_start_i) m_ovr[d] = 0;
    if (swap) begin
      m_act[d] = m_shad[d];
      m_pend[d] = 0;
      m_upd[d] = 1;
    end
    if (load_start_i) begin
      m_open[d] = 1; m_pend[d] = 0; m_cnt[d] = 0;
    end
    if (dat_valid_i && m_open[d]) begin
      m_shad[d][18*m_cnt[d] +: 18] = dat_i;
      m_cnt[d]++;
      if (m_cnt[d] == NTAPS) begin
        m_open[d] = 0; m_pend[d] = 1;
      end
    end
  endfunction

  function automatic snap_t model_snap(input int d);
    snap_t s;
    s.flags = {m_open[d] | m_pend[d], m_pend[d], m_ovr[d], m_upd[d]};
    s.bank  = m_act[d];
    return s;
  endfunction

  task automatic drive(input logic rst, input logic st, input logic vl,
                       input logic [17:0] d, input logic ue);
    @(negedge clk);
    rst_i = rst; load_start_i = st; dat_valid_i = vl; dat_i = d; update_en_i = ue;
    model_step(0);
    model_step(1);
    q0.push_back(model_snap(0));
    q1.push_back(model_snap(1));
  endtask

  task automatic idle(input int n, input logic ue);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 18'h0, ue);
  endtask

  // Open a load, then stream seven words base, base+step, ...
  task automatic load7(input logic [17:0] base, input logic [17:0] step);
    drive(1'b0, 1'b1, 1'b0, 18'h0, 1'b0);
    for (int i = 0; i < NTAPS; i++) drive(1'b0, 1'b0, 1'b1, base + 18'(i) * step, 1'b0);
  endtask

  task automatic compare(input string nm, input int d, input logic [125:0] act,
                         input logic [125:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d @%0t: got %h want %h", nm, d, $time, act, exp);
    end
  endtask

  // Monitor: one cycle of expectations per clock, checked just after the edge.
  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        if ((d == 0) ? (q0.size() != 0) : (q1.size() != 0)) begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          compare("flags", d, 126'({busy[d], armd[d], ovr[d], upd[d]}), 126'(e.flags));
          compare("bank", d, {c6[d], c5[d], c4[d], c3[d], c2[d], c1[d], c0[d]}, e.bank);
        end
      end
    end
  end

  initial begin
    // reset state
    drive(1'b1, 1'b0, 1'b0, 18'h0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 18'h0, 1'b0);
    idle(2, 1'b0);

    // words 1..7 back to back; async swaps on its own, sync needs a strobe
    load7(18'd1, 18'd1);
    idle(3, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);

    // all-ones set held back by a low update_en for 20 cycles
    load7(18'h3FFFF, 18'd0);
    idle(20, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);

    // restart mid-load: the first four words must never surface
    drive(1'b0, 1'b1, 1'b0, 18'h0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 18'd100 + 18'(i), 1'b0);
    drive(1'b0, 1'b1, 1'b1, 18'd9, 1'b0);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 1'b1, 18'd10 + 18'(i), 1'b0);
      idle(i % 3, 1'b0);
    end
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);

    // start together with update_en while armed: start wins, no swap
    load7(18'h00ABC, 18'h00111);
    drive(1'b0, 1'b1, 1'b0, 18'h0, 1'b1);
    idle(3, 1'b1);
    for (int i = 0; i < NTAPS; i++) drive(1'b0, 1'b0, 1'b1, 18'h20000 + 18'(i), 1'b0);
    idle(1, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);

    // stray word in IDLE sets overrun, which sticks until the next start
    drive(1'b0, 1'b0, 1'b1, 18'h12345, 1'b0);
    idle(4, 1'b0);
    load7(18'h00500, 18'h00003);
    drive(1'b0, 1'b0, 1'b1, 18'h3AAAA, 1'b0); // stray while armed (sync)
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);

    // random traffic, including resets and start/valid/update collisions
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 6),
            ($urandom_range(0, 99) < 55), 18'($urandom),
            ($urandom_range(0, 99) < 20));
    end
    idle(4, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
